// File: rtl/imem_pkg.sv
// imem_pkg: definitions shared by the instruction-memory loader and the fetch stage.
package imem_pkg;

   localparam int          IMEM_DEPTH     = 101;
   localparam logic [31:0] IMEM_BASE_ADDR = 32'h0004_0000;
   localparam int          INSTR_W        = 32;
   localparam int          IMEM_CNT_W     = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      WRITE   = 3'd2,
      CHECK   = 3'd3,
      DONE    = 3'd4
   } imem_state_t;

   // Byte address of an instruction-memory line; wraps modulo 2^32.
   function automatic logic [31:0] lineToPc(input logic [31:0] line, input logic [31:0] base);
      return base + (line << 2);
   endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs a MSB-first byte stream into 32-bit words.
// o_word_valid pulses combinationally while the 4th byte of a word is being
// accepted, and o_word already contains that byte in its low lane.
module imem_word_assembler
   import imem_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_byte_valid,
   input  logic               i_byte_ready,
   input  logic [7:0]         i_byte_data,
   output logic               o_word_valid,
   output logic [INSTR_W-1:0] o_word
);

   logic [1:0]         r_count;
   logic [INSTR_W-1:0] r_shift;
   logic               w_fire;

   assign w_fire       = i_byte_valid & i_byte_ready;
   assign o_word_valid = w_fire && (r_count == 2'd3);
   assign o_word       = {r_shift[INSTR_W-9:0], i_byte_data};

   // Shift each accepted byte in and count bytes; the 2-bit counter wraps to 0 after the 4th byte
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_count <= 2'd0;
         r_shift <= '0;
      end else if (w_fire) begin
         r_shift <= o_word;
         r_count <= r_count + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory. Streams bytes in over a
// valid/ready handshake, builds big-endian words and writes them to lines
// 0..num_words-1 while holding the fetch stage in reset.
// Optional checksum trailer: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_pkg::*;
#(
   parameter int          DEPTH     = IMEM_DEPTH,
   parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
   parameter int          CNT_W     = IMEM_CNT_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [31:0]      mem_line,
   output logic [31:0]      mem_wdata,
   output logic [31:0]      pc_addr,
   output logic             busy,
   output logic             fetch_hold,
   output logic             done,
   output logic             err
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   imem_state_t        r_state;
   logic [CNT_W-1:0]   r_index;
   logic [CNT_W-1:0]   r_num_words;
   logic               r_byte_ready;
   logic               r_mem_we;
   logic [31:0]        r_mem_wdata;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [INSTR_W-1:0] r_xor;
`endif

   logic               w_word_valid;
   logic [INSTR_W-1:0] w_word;
   logic [31:0]        w_line;

   imem_word_assembler u_assembler (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_byte_valid (byte_valid),
      .i_byte_ready (r_byte_ready),
      .i_byte_data  (byte_data),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   assign w_line     = 32'(r_index);
   assign byte_ready = r_byte_ready;
   assign mem_we     = r_mem_we;
   assign mem_line   = w_line;
   assign mem_wdata  = r_mem_wdata;
   assign pc_addr    = lineToPc(w_line, BASE_ADDR);
   assign busy       = r_busy;
   assign fetch_hold = r_busy;
   assign done       = r_done;
   assign err        = r_err;

   // Load sequencer: every output is registered together with the state it belongs to
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_index      <= '0;
         r_num_words  <= '0;
         r_byte_ready <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_wdata  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_xor        <= '0;
`endif
      end else begin
         r_mem_we <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (num_words == '0) begin
                     r_err   <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else if (num_words > DEPTH_C) begin
                     r_err <= 1'b1;
                  end else begin
                     r_err        <= 1'b0;
                     r_num_words  <= num_words;
                     r_index      <= '0;
                     r_busy       <= 1'b1;
                     r_byte_ready <= 1'b1;
                     r_state      <= COLLECT;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_xor        <= '0;
`endif
                  end
               end
            end
            COLLECT: begin
               if (w_word_valid) begin
                  r_mem_we     <= 1'b1;
                  r_mem_wdata  <= w_word;
                  r_byte_ready <= 1'b0;
                  r_state      <= WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_xor        <= r_xor ^ w_word;
`endif
               end
            end
            WRITE: begin
               if (r_index == r_num_words - ONE_C) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_byte_ready <= 1'b1;
                  r_state      <= CHECK;
`else
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_index <= '0;
                  r_state <= DONE;
`endif
               end else begin
                  r_index      <= r_index + ONE_C;
                  r_byte_ready <= 1'b1;
                  r_state      <= COLLECT;
               end
            end
            CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               if (w_word_valid) begin
                  r_err        <= (w_word != r_xor);
                  r_byte_ready <= 1'b0;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
                  r_index      <= '0;
                  r_state      <= DONE;
               end
`else
               r_state <= IDLE;
`endif
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory; the fetch stage is the reader.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into consecutive instruction-memory lines starting at line 0.
- Holds the fetch stage in reset while a program load is in progress, so the core only starts after the image is complete.

Parameters:
- DEPTH, 101: number of instruction-memory lines (line indices 0..DEPTH-1).
- BASE_ADDR, 32'h0004_0000: byte address of line 0, reported on pc_addr. Line n maps to BASE_ADDR + 4*n.
- CNT_W, 16: width of num_words.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- num_words  in  CNT_W  words to load; sampled with start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte, MSB-first within each word.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe.
- mem_line  out  32  word index being written.
- mem_wdata  out  32  assembled instruction.
- pc_addr  out  32  BASE_ADDR + 4*mem_line; the PC value for the word being written.
- busy  out  1  load in progress.
- fetch_hold  out  1  equals busy; fetch PC is held in reset while high.
- done  out  1  one-cycle pulse at end of load.
- err  out  1  sticky error, cleared by the next accepted start.

Behaviour:
- Reset values (while rst=0): every output is 0, state=IDLE, word index=0, byte count=0, shift register=0. pc_addr reads BASE_ADDR because mem_line=0.
- Byte transfer: a byte transfers on a posedge when byte_valid && byte_ready are both high. byte_ready depends only on state, never on byte_valid.

State machine:
- IDLE:
  - byte_ready=0, busy=0.
  - start with num_words==0 -> DONE; no writes occur.
  - start with num_words > DEPTH -> err=1, stay IDLE, no writes.
  - start otherwise -> COLLECT. Latch num_words, clear err, index=0.
- COLLECT:
  - byte_ready=1, busy=1.
  - Each transferred byte: shift={shift[23:0],byte_data}, count++.
  - On the 4th byte -> WRITE, count=0.
  - byte_valid low: wait indefinitely; no timeout.
- WRITE:
  - Exactly one cycle. mem_we=1, mem_wdata=shift, mem_line=index; byte_ready=0.
  - If index == latched num_words - 1 -> DONE (or CHECK when the optional feature is on).
  - Otherwise index++ and return to COLLECT.
- DONE:
  - done=1 for one cycle, busy=0.
  - Next state IDLE, mem_line returns to 0.

Timing and boundary conditions:
- Latency: the mem_we cycle is the cycle immediately after the 4th byte transfers. Minimum of 5 cycles per word.
- Index limits: the index never exceeds DEPTH-1. The last line is written when num_words==DEPTH.
- start while busy is ignored; err is unchanged.
- Reset mid-load aborts the load. The partial word is discarded, no write strobe occurs, and lines already written stay in memory.
- start and byte_valid asserted in the same IDLE cycle: the byte is not consumed; byte_ready goes high the next cycle.
- Arithmetic: index comparisons use CNT_W bits, zero-extended to 32 bits for mem_line. pc_addr is computed modulo 2^32.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - The loader keeps a running XOR of all written words, cleared at start.
  - After the last WRITE it enters CHECK: it collects 4 more bytes with the same handshake and performs no write.
  - A mismatch between the collected word and the running XOR sets err=1 in the cycle done pulses.
  - DONE is entered one cycle after the 4th checksum byte.
- Without the macro: no CHECK state, no XOR register; the byte stream contains exactly 4*num_words bytes.

Decomposition:
- Shared package imem_pkg, used by both imem_loader and the fetch stage:
  - state enum (IDLE, COLLECT, WRITE, CHECK, DONE);
  - IMEM_DEPTH = 101;
  - IMEM_BASE_ADDR = 32'h0004_0000;
  - INSTR_W = 32.
- One sub-module: imem_word_assembler. It holds the byte counter and shift register, takes byte_valid/byte_ready/byte_data, and outputs a word_valid pulse with the 32-bit word. The FSM stays in imem_loader.

Test Plan:
1. Reset: rst=0 with random inputs -> all outputs 0, pc_addr=32'h0004_0000; release rst -> state IDLE.
2. Load 2 words: start with num_words=2, bytes 7C 22 1A 14 38 21 00 05 with byte_valid held high ->
   - mem_we pulses twice: line 0 data 32'h7C221A14, then line 1 data 32'h38210005;
   - pc_addr shows 32'h00040000 and 32'h00040004;
   - done pulses one cycle after the second write;
   - busy/fetch_hold high throughout.
3. Stalls: same load with byte_valid toggled every other cycle -> identical writes, byte count never advances on byte_valid=0.
4. Bounds:
   - num_words=0 -> done the next cycle, no mem_we;
   - num_words=102 -> err=1, no writes, busy stays 0;
   - num_words=101 -> last write at mem_line=100.
5. Reset mid-word: after 2 bytes of word 1, pull rst low -> no mem_we, line 0 retains its data, IDLE after release; a new start clears err.
6. Checksum (IMEM_LOADER_CHECKSUM_EN): words 32'h11111111 and 32'h22222222, checksum 32'h33333333 -> err=0 at done; checksum 32'h33333330 -> err=1.
